// File: rtl/alu_pkg.sv
// Shared opcode values, flag record and flag helper for the TinyFPGA_VGA ALU.
// The CPU decoder and the bench import this package so that the opcodes are defined once.
package alu_pkg;

  localparam int DATA_W = 16;

  // Arithmetic/logic group
  localparam logic [2:0] ADD_OP = 3'd0;
  localparam logic [2:0] ADC_OP = 3'd1;
  localparam logic [2:0] SUB_OP = 3'd2;
  localparam logic [2:0] SBC_OP = 3'd3;
  localparam logic [2:0] AND_OP = 3'd4;
  localparam logic [2:0] OR_OP  = 3'd5;
  localparam logic [2:0] XOR_OP = 3'd6;
  localparam logic [2:0] NOT_OP = 3'd7;

  // Shift/rotate group
  localparam logic [2:0] SHL_OP  = 3'd0;
  localparam logic [2:0] SHR_OP  = 3'd1;
  localparam logic [2:0] ASHR_OP = 3'd2;
  localparam logic [2:0] ROL_OP  = 3'd3;
  localparam logic [2:0] ROR_OP  = 3'd4;

  // Load/byte group
  localparam logic [2:0] COPY_OP = 3'd0;
  localparam logic [2:0] SWAP_OP = 3'd1;
  localparam logic [2:0] LDL_OP  = 3'd2;
  localparam logic [2:0] LDH_OP  = 3'd3;

  typedef struct packed {
    logic c;
    logic z;
    logic n;
  } flags_t;

  function automatic flags_t computeFlags(input logic [DATA_W-1:0] value, input logic carry);
    flags_t f;
    f.c = carry;
    f.z = (value == '0);
    f.n = value[DATA_W-1];
    return f;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Single-bit shift/rotate unit; carryIn doubles as the rotate fill bit.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] operand1,
  input  logic              carryIn,
  input  logic [2:0]        operation,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  always_comb begin
    result = operand1;
    carry  = carryIn;
    case (operation)
      SHL_OP: begin
        result = {operand1[DATA_W-2:0], 1'b0};
        carry  = operand1[DATA_W-1];
      end
      SHR_OP: begin
        result = {1'b0, operand1[DATA_W-1:1]};
        carry  = operand1[0];
      end
      ASHR_OP: begin
        result = {operand1[DATA_W-1], operand1[DATA_W-1:1]};
        carry  = operand1[0];
      end
      ROL_OP: begin
        result = {operand1[DATA_W-2:0], carryIn};
        carry  = operand1[DATA_W-1];
      end
      ROR_OP: begin
        result = {carryIn, operand1[DATA_W-1:1]};
        carry  = operand1[0];
      end
      default: begin
        result = operand1;
        carry  = carryIn;
      end
    endcase
  end

endmodule

// File: rtl/alu.sv
// 16-bit combinational ALU with a clocked C/Z/N status register.
// Group priority: enableAlu, then enableShift, then enableLoad.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] operand1,
  input  logic [DATA_W-1:0] operand2,
  input  logic              carryIn,
  input  logic [2:0]        operation,
  input  logic              enableAlu,
  input  logic              enableShift,
  input  logic              enableLoad,
  output logic [DATA_W-1:0] result,
  output logic              carryOut,
  output logic              zeroOut,
  output logic              negativeOut,
  output logic              statusC,
  output logic              statusZ,
  output logic              statusN
);

  logic [DATA_W-1:0] shiftResult;
  logic              shiftCarry;
  logic [DATA_W-1:0] addend;
  logic              addCarry;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] aluResult;
  logic              aluCarry;
  logic [DATA_W-1:0] loadResult;
  flags_t            flags;
  flags_t            status;

  alu_shifter uShifter (
    .operand1  (operand1),
    .carryIn   (carryIn),
    .operation (operation),
    .result    (shiftResult),
    .carry     (shiftCarry)
  );

  // Subtraction is a + ~b + 1 (or + carryIn for SBC), so carry set means no borrow.
  always_comb begin
    addend   = operand2;
    addCarry = 1'b0;
    case (operation)
      ADC_OP: addCarry = carryIn;
      SUB_OP: begin
        addend   = ~operand2;
        addCarry = 1'b1;
      end
      SBC_OP: begin
        addend   = ~operand2;
        addCarry = carryIn;
      end
      default: begin
        addend   = operand2;
        addCarry = 1'b0;
      end
    endcase
    sum = {1'b0, operand1} + {1'b0, addend} + {{DATA_W{1'b0}}, addCarry};
  end

  always_comb begin
    aluResult = sum[DATA_W-1:0];
    aluCarry  = sum[DATA_W];
    case (operation)
      AND_OP: begin
        aluResult = operand1 & operand2;
        aluCarry  = carryIn;
      end
      OR_OP: begin
        aluResult = operand1 | operand2;
        aluCarry  = carryIn;
      end
      XOR_OP: begin
        aluResult = operand1 ^ operand2;
        aluCarry  = carryIn;
      end
      NOT_OP: begin
        aluResult = ~operand1;
        aluCarry  = carryIn;
      end
      default: begin
        aluResult = sum[DATA_W-1:0];
        aluCarry  = sum[DATA_W];
      end
    endcase
  end

  always_comb begin
    case (operation)
      SWAP_OP: loadResult = {operand1[7:0], operand1[15:8]};
      LDL_OP:  loadResult = {8'h00, operand1[7:0]};
      LDH_OP:  loadResult = {8'h00, operand1[15:8]};
      default: loadResult = operand1;
    endcase
  end

  always_comb begin
    result   = '0;
    carryOut = carryIn;
    if (enableAlu) begin
      result   = aluResult;
      carryOut = aluCarry;
    end else if (enableShift) begin
      result   = shiftResult;
      carryOut = shiftCarry;
    end else if (enableLoad) begin
      result   = loadResult;
      carryOut = carryIn;
    end
    flags       = computeFlags(result, carryOut);
    zeroOut     = flags.z;
    negativeOut = flags.n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status <= '0;
    end else if (enableAlu || enableShift || enableLoad) begin
      status <= flags;
    end
  end

  assign statusC = status.c;
  assign statusZ = status.z;
  assign statusN = status.n;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, randomized model checks and status sequences.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [15:0] operand1;
  logic [15:0] operand2;
  logic        carryIn;
  logic [2:0]  operation;
  logic        enableAlu;
  logic        enableShift;
  logic        enableLoad;
  logic [15:0] result;
  logic        carryOut;
  logic        zeroOut;
  logic        negativeOut;
  logic        statusC;
  logic        statusZ;
  logic        statusN;

  int errors = 0;
  int checks = 0;
  logic [2:0] expStat;

  alu dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .operand1    (operand1),
    .operand2    (operand2),
    .carryIn     (carryIn),
    .operation   (operation),
    .enableAlu   (enableAlu),
    .enableShift (enableShift),
    .enableLoad  (enableLoad),
    .result      (result),
    .carryOut    (carryOut),
    .zeroOut     (zeroOut),
    .negativeOut (negativeOut),
    .statusC     (statusC),
    .statusZ     (statusZ),
    .statusN     (statusN)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // en = {alu, shift, load}
  typedef struct {
    string       name;
    logic [2:0]  en;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [15:0] expR;
    logic        expC;
    logic        expZ;
    logic        expN;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model in plain integer arithmetic.
  task automatic refModel(input logic [2:0] en, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic c,
                          output logic [15:0] r, output logic co);
    int ai, bi, ci, s, ri;
    ai = int'(a); bi = int'(b); ci = int'(c);
    ri = 0; co = c;
    if (en[2]) begin
      if (op <= 3) begin
        case (op)
          3'd0: s = ai + bi;
          3'd1: s = ai + bi + ci;
          3'd2: s = ai + (65535 - bi) + 1;
          default: s = ai + (65535 - bi) + ci;
        endcase
        ri = s % 65536;
        co = (s > 65535);
      end else begin
        case (op)
          3'd4: ri = int'(a & b);
          3'd5: ri = int'(a | b);
          3'd6: ri = int'(a ^ b);
          default: ri = 65535 - ai;
        endcase
      end
    end else if (en[1]) begin
      case (op)
        3'd0: begin ri = (ai * 2) % 65536; co = (ai >= 32768); end
        3'd1: begin ri = ai / 2; co = (ai % 2) == 1; end
        3'd2: begin ri = ai / 2 + ((ai >= 32768) ? 32768 : 0); co = (ai % 2) == 1; end
        3'd3: begin ri = (ai * 2) % 65536 + ci; co = (ai >= 32768); end
        3'd4: begin ri = ai / 2 + ci * 32768; co = (ai % 2) == 1; end
        default: ri = ai;
      endcase
    end else if (en[0]) begin
      case (op)
        3'd1: ri = (ai % 256) * 256 + ai / 256;
        3'd2: ri = ai % 256;
        3'd3: ri = ai / 256;
        default: ri = ai;
      endcase
    end
    r = 16'(ri);
  endtask

  // Drive after negedge, check combinational outputs, then check status after the posedge.
  task automatic applyCheck(input string name, input logic [2:0] en, input logic [2:0] op,
                            input logic [15:0] a, input logic [15:0] b, input logic c,
                            input logic [15:0] expR, input logic expC, input logic expZ,
                            input logic expN);
    @(negedge clk);
    {enableAlu, enableShift, enableLoad} = en;
    operation = op; operand1 = a; operand2 = b; carryIn = c;
    #1;
    chk({name, ".r"}, result, expR);
    chk({name, ".c"}, 16'(carryOut), 16'(expC));
    chk({name, ".z"}, 16'(zeroOut), 16'(expZ));
    chk({name, ".n"}, 16'(negativeOut), 16'(expN));
    if (en != 3'b000) expStat = {expC, expZ, expN};
    @(posedge clk);
    #1;
    chk({name, ".stat"}, 16'({statusC, statusZ, statusN}), 16'(expStat));
  endtask

  initial begin
    logic [15:0] mr;
    logic        mc;
    logic [2:0]  ren, rop;
    logic [15:0] ra, rb;
    logic        rc;

    vecs[0]  = '{"adc",    3'b100, ADC_OP,  16'h000A, 16'h000F, 1'b1, 16'h001A, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"add",    3'b100, ADD_OP,  16'hF000, 16'h1243, 1'b0, 16'h0243, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"sub",    3'b100, SUB_OP,  16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{"shl0",   3'b010, SHL_OP,  16'h8234, 16'h0000, 1'b0, 16'h0468, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"shl1",   3'b010, SHL_OP,  16'h8234, 16'h0000, 1'b1, 16'h0468, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{"ashr4",  3'b010, ASHR_OP, 16'h8234, 16'h0000, 1'b0, 16'hC11A, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{"ashr5",  3'b010, ASHR_OP, 16'h8235, 16'h0000, 1'b0, 16'hC11A, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{"shr",    3'b010, SHR_OP,  16'h8235, 16'h0000, 1'b0, 16'h411A, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"rol0",   3'b010, ROL_OP,  16'h8235, 16'h0000, 1'b0, 16'h046A, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"rol1",   3'b010, ROL_OP,  16'h8235, 16'h0000, 1'b1, 16'h046B, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{"ror0",   3'b010, ROR_OP,  16'h8235, 16'h0000, 1'b0, 16'h411A, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{"ror1",   3'b010, ROR_OP,  16'h8235, 16'h0000, 1'b1, 16'hC11A, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{"not",    3'b100, NOT_OP,  16'h8235, 16'h0000, 1'b0, 16'h7DCA, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"copy",   3'b001, COPY_OP, 16'h8235, 16'h0000, 1'b1, 16'h8235, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{"swap",   3'b001, SWAP_OP, 16'h8235, 16'h0000, 1'b1, 16'h3582, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{"ldl",    3'b001, LDL_OP,  16'h8235, 16'h0000, 1'b1, 16'h0035, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{"ldh",    3'b001, LDH_OP,  16'h8235, 16'h0000, 1'b1, 16'h0082, 1'b1, 1'b0, 1'b0};
    vecs[17] = '{"allen",  3'b111, ADD_OP,  16'hF000, 16'h1243, 1'b0, 16'h0243, 1'b1, 1'b0, 1'b0};
    vecs[18] = '{"idle",   3'b000, ADD_OP,  16'h8235, 16'h1243, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[19] = '{"shftin", 3'b011, SHL_OP,  16'h4001, 16'h0000, 1'b1, 16'h8002, 1'b0, 1'b0, 1'b1};

    reset_n = 1'b0;
    {enableAlu, enableShift, enableLoad} = 3'b000;
    operation = 3'd0; operand1 = 16'h0; operand2 = 16'h0; carryIn = 1'b0;
    expStat = 3'b000;
    #12;
    chk("rst.stat", 16'({statusC, statusZ, statusN}), 16'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Status: ADD latches C=1, then idle holds even though idle flags differ.
    applyCheck("statAdd", 3'b100, ADD_OP, 16'hF000, 16'h1243, 1'b0, 16'h0243, 1'b1, 1'b0, 1'b0);
    applyCheck("statHold", 3'b000, ADD_OP, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    foreach (vecs[i])
      applyCheck(vecs[i].name, vecs[i].en, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
                 vecs[i].expR, vecs[i].expC, vecs[i].expZ, vecs[i].expN);

    // Asynchronous reset mid-run: flags must clear with no clock edge.
    applyCheck("preRst", 3'b010, ASHR_OP, 16'h8235, 16'h0000, 1'b0, 16'hC11A, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    {enableAlu, enableShift, enableLoad} = 3'b000;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midRst.stat", 16'({statusC, statusZ, statusN}), 16'h0);
    expStat = 3'b000;
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      ren = 3'($urandom_range(0, 7));
      rop = 3'($urandom_range(0, 7));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      if (i % 16 == 0) rb = ra;
      refModel(ren, rop, ra, rb, rc, mr, mc);
      applyCheck("rand", ren, rop, ra, rb, rc, mr, mc, (mr == 16'h0), mr[15]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
